// File: rtl/multi_sonic_ctl.sv
// Generic synchronous FIFO with registered read data (not first-word-fall-through).
// Latency: rd_dat updates one cycle after an accepted rd_en; full/empty registered.
// Backpressure: writes are dropped while full unless a read frees a slot in the same cycle.
module sonic_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_en,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_n;
    logic             do_rd, do_wr;

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        count_n = count;
        if (do_wr && !do_rd)
            count_n = count + CNT_ONE;
        else if (do_rd && !do_wr)
            count_n = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            rd_dat <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rd_dat <= mem[rd_ptr];
            end
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_dat;
    end
endmodule

// Multi-channel single-wire ultrasonic controller: command FIFO -> trigger/echo FSM -> response FIFO.
// Latency: one response per channel measured, TRIG + echo + sync delay; dout one cycle after rd_en.
// Backpressure: commands dropped while full; FSM stalls in PUSH with pins released while responses are full.
module multi_sonic_ctl #(
    parameter int CH_NUM         = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int CNT_W          = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       din,
    input  logic              wr_en,
    output logic              full,
    output logic [31:0]       dout,
    input  logic              rd_en,
    output logic              empty,
    inout  wire  [CH_NUM-1:0] sig,
    output logic              busy
);
    typedef enum logic [2:0] {
        IDLE, DECODE, TRIG, WAIT_RISE, MEASURE, PUSH, HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       CH_LAST     = 4'(CH_NUM - 1);

    state_t           state, state_n;
    logic [3:0]       ch, ch_n;
    logic             scan, scan_n;
    logic [1:0]       status, status_n;
    logic [CNT_W-1:0] tmr, tmr_n, wid, wid_n;

    logic [4:0]        cmd_dat;
    logic              cmd_empty, cmd_rd;
    logic              resp_full, resp_wr;
    logic [31:0]       resp_dat;
    logic [CH_NUM-1:0] sig_s1, sig_s2, sig_s3;
    logic [15:0]       s2_pad, s3_pad;
    logic              echo_rise, echo_hi;
    logic              unused_din_bits;

    assign unused_din_bits = ^{din[31:9], din[7:4]};

    // Only mode and channel survive into the command queue.
    sonic_fifo #(.WIDTH(5), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_dat ({din[8], din[3:0]}),
        .wr_en  (wr_en),
        .full   (full),
        .rd_dat (cmd_dat),
        .rd_en  (cmd_rd),
        .empty  (cmd_empty)
    );

    sonic_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_dat (resp_dat),
        .wr_en  (resp_wr),
        .full   (resp_full),
        .rd_dat (dout),
        .rd_en  (rd_en),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_s1 <= '0;
            sig_s2 <= '0;
            sig_s3 <= '0;
        end else begin
            sig_s1 <= sig;
            sig_s2 <= sig_s1;
            sig_s3 <= sig_s2;
        end
    end

    // s3 is the synchronised echo one cycle later, so MEASURE counts the rising-edge cycle too.
    assign s2_pad    = 16'(sig_s2);
    assign s3_pad    = 16'(sig_s3);
    assign echo_rise = s2_pad[ch] && !s3_pad[ch];
    assign echo_hi   = s3_pad[ch];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_pin
        assign sig[i] = (state == TRIG && ch == 4'(i)) ? 1'b1 : 1'bz;
    end

    assign resp_dat = {status, 2'b00, ch, 24'(wid)};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= '0;
            scan   <= 1'b0;
            status <= '0;
            tmr    <= '0;
            wid    <= '0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            scan   <= scan_n;
            status <= status_n;
            tmr    <= tmr_n;
            wid    <= wid_n;
        end
    end

    always_comb begin
        state_n  = state;
        ch_n     = ch;
        scan_n   = scan;
        status_n = status;
        tmr_n    = tmr;
        wid_n    = wid;
        cmd_rd   = 1'b0;
        resp_wr  = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty) begin
                    cmd_rd  = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                scan_n   = cmd_dat[4];
                tmr_n    = '0;
                wid_n    = '0;
                status_n = 2'b00;
                if (!cmd_dat[4] && cmd_dat[3:0] > CH_LAST) begin
                    ch_n     = cmd_dat[3:0];
                    status_n = 2'b10;
                    state_n  = PUSH;
                end else begin
                    ch_n    = cmd_dat[4] ? 4'd0 : cmd_dat[3:0];
                    state_n = TRIG;
                end
            end
            TRIG: begin
                tmr_n = tmr + CNT_ONE;
                if (tmr == TRIG_LAST) begin
                    tmr_n   = '0;
                    state_n = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                tmr_n = tmr + CNT_ONE;
                if (echo_rise) begin
                    wid_n   = '0;
                    state_n = MEASURE;
                end else if (tmr_n == TIMEOUT_VAL) begin
                    status_n = 2'b01;
                    wid_n    = '0;
                    state_n  = PUSH;
                end
            end
            MEASURE: begin
                if (echo_hi) begin
                    tmr_n = tmr + CNT_ONE;
                    wid_n = wid + CNT_ONE;
                    if (tmr_n == TIMEOUT_VAL) begin
                        status_n = 2'b01;
                        state_n  = PUSH;
                    end
                end else begin
                    status_n = 2'b00;
                    state_n  = PUSH;
                end
            end
            PUSH: begin
                if (!resp_full) begin
                    resp_wr = 1'b1;
                    tmr_n   = '0;
                    state_n = (status == 2'b10) ? IDLE : HOLDOFF;
                end
            end
            HOLDOFF: begin
                tmr_n = tmr + CNT_ONE;
                if (tmr == HOLD_LAST) begin
                    tmr_n = '0;
                    if (scan && ch != CH_LAST) begin
                        ch_n     = ch + 4'd1;
                        status_n = 2'b00;
                        wid_n    = '0;
                        state_n  = TRIG;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multi_sonic_ctl.sv
// Bench for multi_sonic_ctl: a per-channel sensor model answers triggers with programmed echoes.
module tb_multi_sonic_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        full, empty, busy;
    logic [31:0] dout;
    wire  [3:0]  sig;

    int errors = 0;
    int checks = 0;

    logic [3:0] drv_en = '0;
    bit         model_kill = 1'b1;
    bit         echo_on  [4] = '{default: 1'b0};
    int         echo_dly [4] = '{default: 0};
    int         echo_wid [4] = '{default: 0};
    int         mst      [4] = '{default: 0};
    int         mcnt     [4] = '{default: 0};
    int         trig_run [4] = '{default: 0};
    int         trig_len [4] = '{default: 0};
    int         trig_total [4] = '{default: 0};

    always #5 clk = ~clk;

    multi_sonic_ctl #(
        .CH_NUM(4), .FIFO_DEPTH(4), .TRIG_CYCLES(4),
        .TIMEOUT_CYCLES(100), .HOLDOFF_CYCLES(8), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
        .dout(dout), .rd_en(rd_en), .empty(empty), .sig(sig), .busy(busy)
    );

    for (genvar i = 0; i < 4; i++) begin : g_sensor
        assign sig[i] = drv_en[i] ? 1'b1 : 1'bz;
        pulldown (sig[i]);
    end

    // Sensor model: measure the trigger pulse, then after release wait echo_dly and drive echo_wid cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (model_kill) begin
                mst[i]      <= 0;
                drv_en[i]   <= 1'b0;
                trig_run[i] <= 0;
            end else begin
                case (mst[i])
                    0: begin
                        if (sig[i] === 1'b1) begin
                            trig_run[i] <= trig_run[i] + 1;
                        end else if (trig_run[i] > 0) begin
                            trig_len[i]   <= trig_run[i];
                            trig_total[i] <= trig_total[i] + 1;
                            trig_run[i]   <= 0;
                            if (echo_on[i]) begin
                                mst[i]  <= 1;
                                mcnt[i] <= echo_dly[i];
                            end
                        end
                    end
                    1: begin
                        if (mcnt[i] <= 1) begin
                            drv_en[i] <= 1'b1;
                            mcnt[i]   <= echo_wid[i];
                            mst[i]    <= 2;
                        end else begin
                            mcnt[i] <= mcnt[i] - 1;
                        end
                    end
                    default: begin
                        if (mcnt[i] <= 1) begin
                            drv_en[i] <= 1'b0;
                            mst[i]    <= 0;
                        end else begin
                            mcnt[i] <= mcnt[i] - 1;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [31:0] exp_word(input int ch, input bit on, input int w);
        if (ch >= 4) return {2'b10, 2'b00, 4'(ch), 24'd0};
        if (!on)     return {2'b01, 2'b00, 4'(ch), 24'd0};
        return {2'b00, 2'b00, 4'(ch), 24'(w)};
    endfunction

    function automatic int trig_sum();
        return trig_total[0] + trig_total[1] + trig_total[2] + trig_total[3];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_cmd(input logic [31:0] d);
        din   = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_word(output logic [31:0] w);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        w = dout;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_nonempty(input int max, input string tag);
        int n = 0;
        while (empty && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(empty), 32'd0);
    endtask

    task automatic run_single(input logic [31:0] cmd, input string tag, output logic [31:0] w);
        write_cmd(cmd);
        repeat (3) @(negedge clk);
        wait_idle(2000, {tag, "_idle"});
        wait_nonempty(20, {tag, "_resp"});
        read_word(w);
    endtask

    initial begin
        logic [31:0] w;
        logic [5:0]  fv;
        int          t0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_dout", dout, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        model_kill = 1'b0;
        @(negedge clk);

        // single ok on channel 2
        echo_on[2] = 1'b1; echo_dly[2] = 10; echo_wid[2] = 37;
        run_single(32'h0000_0002, "single", w);
        check("single_word", w, 32'h0200_0025);
        check("single_trig_len", 32'(trig_len[2]), 32'd4);
        check("single_busy", 32'(busy), 32'd0);

        // timeout with no echo, then a normal command afterwards
        echo_on[1] = 1'b0;
        run_single(32'h0000_0001, "timeout", w);
        check("timeout_word", w, 32'h4100_0000);
        echo_on[2] = 1'b1; echo_dly[2] = 5; echo_wid[2] = 12;
        run_single(32'h0000_0002, "after_to", w);
        check("after_to_word", w, exp_word(2, 1'b1, 12));

        // echo longer than the timeout
        echo_on[1] = 1'b1; echo_dly[1] = 10; echo_wid[1] = 200;
        run_single(32'h0000_0001, "long", w);
        check("long_status", 32'(w[31:30]), 32'd1);
        check("long_chan", 32'(w[27:24]), 32'd1);
        check("long_width_range", 32'(w[23:0] > 0 && w[23:0] < 100), 32'd1);
        repeat (250) @(negedge clk);

        // bad channel
        t0 = trig_sum();
        run_single(32'h0000_0007, "bad", w);
        check("bad_word", w, 32'h8700_0000);
        check("bad_no_trig", 32'(trig_sum() - t0), 32'd0);

        // scan all channels
        for (int i = 0; i < 4; i++) begin
            echo_on[i] = 1'b1; echo_dly[i] = 6; echo_wid[i] = 5 + i;
        end
        t0 = trig_sum();
        write_cmd(32'h0000_0100);
        repeat (3) @(negedge clk);
        wait_idle(3000, "scan_idle");
        for (int i = 0; i < 4; i++) begin
            wait_nonempty(20, "scan_resp");
            read_word(w);
            check("scan_word", w, exp_word(i, 1'b1, 5 + i));
        end
        check("scan_drained", 32'(empty), 32'd1);
        check("scan_trigs", 32'(trig_sum() - t0), 32'd4);

        // command FIFO full and response FIFO backpressure
        echo_on[1] = 1'b0;
        t0 = trig_total[1];
        write_cmd(32'h0000_0001);
        repeat (3) @(negedge clk);
        check("bp_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            fv[i] = full;
            din   = 32'h0000_0001;
            wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("bp_full_seq", 32'(fv), 32'h30);
        check("bp_full_after", 32'(full), 32'd1);
        repeat (800) @(negedge clk);
        check("bp_stall_busy", 32'(busy), 32'd1);
        check("bp_stall_trigs", 32'(trig_total[1] - t0), 32'd5);
        check("bp_cmd_drained", 32'(full), 32'd0);
        read_word(w);
        check("bp_first", w, 32'h4100_0000);
        wait_idle(300, "bp_resume");
        for (int i = 0; i < 4; i++) begin
            wait_nonempty(20, "bp_resp");
            read_word(w);
            check("bp_word", w, 32'h4100_0000);
        end
        check("bp_empty", 32'(empty), 32'd1);
        read_word(w);
        check("bp_rd_empty_hold", w, 32'h4100_0000);

        // randomized single commands against the model
        for (int k = 0; k < 10; k++) begin
            int          ch, d, wd;
            bit          on;
            logic [31:0] r;
            ch = int'($urandom_range(0, 5));
            on = ($urandom_range(0, 3) != 0);
            d  = int'($urandom_range(2, 30));
            wd = int'($urandom_range(1, 45));
            if (ch < 4) begin
                echo_on[ch] = on; echo_dly[ch] = d; echo_wid[ch] = wd;
            end
            r  = $urandom;
            t0 = trig_sum();
            run_single((r & 32'hFFFF_FEF0) | 32'(ch), "rand", w);
            check("rand_word", w, exp_word(ch, on, wd));
            check("rand_trigs", 32'(trig_sum() - t0), (ch < 4) ? 32'd1 : 32'd0);
        end

        // reset during MEASURE
        echo_on[3] = 1'b1; echo_dly[3] = 5; echo_wid[3] = 60;
        t0 = trig_sum();
        write_cmd(32'h0000_0003);
        begin
            int n = 0;
            while (!drv_en[3] && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("mrst_echo_seen", 32'(drv_en[3]), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        model_kill = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_full", 32'(full), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_dout", dout, 32'd0);
        repeat (3) @(negedge clk);
        check("mrst_sig", 32'(sig), 32'd0);
        model_kill = 1'b0;
        repeat (200) @(negedge clk);
        check("mrst_no_resp", 32'(empty), 32'd1);
        check("mrst_no_retrig", 32'(trig_sum() - t0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_sonic_ctl.md
Name: multi_sonic_ctl

Overview:
- Parametrised successor to the single-channel ultrasonic sensor controller.
- Drives up to 16 single-wire (trigger/echo on one bidirectional pin) ultrasonic sensors from a 32-bit command stream and returns 32-bit measurement words.
- Contains its own command and response FIFOs, a trigger/echo timing FSM with timeout, and a scan-all mode.
- Sits between the host 32-bit write/read stream pair and the sensor pins in the top module.

Parameters:
- CH_NUM, 4, number of sensor channels (1..16).
- FIFO_DEPTH, 16, entries in each of the command and response FIFOs (power of two, >=2).
- TRIG_CYCLES, 500, clk cycles the trigger pulse is driven high.
- TIMEOUT_CYCLES, 2000000, maximum clk cycles from trigger release to echo fall.
- HOLDOFF_CYCLES, 1000, idle gap after each measurement before the next trigger.
- CNT_W, 24, width of the echo-width counter (TIMEOUT_CYCLES < 2**CNT_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din  in  32  command word.
- wr_en  in  1  command write strobe.
- full  out  1  command FIFO full.
- dout  out  32  response word.
- rd_en  in  1  response read strobe.
- empty  out  1  response FIFO empty.
- sig  inout  CH_NUM  sensor pins, one per channel.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled at posedge clk.
- Reset values:
  - full=0, empty=1, dout=0, busy=0.
  - All sig pins released (Z).
  - Both FIFOs flushed, FSM in IDLE, all counters 0.
- Reset mid-measurement:
  - Pins are released at the same edge.
  - No response word is emitted.
- Command word fields:
  - din[3:0]: channel.
  - din[8]: mode (0 = single, 1 = scan all channels 0..CH_NUM-1 in order; channel field ignored).
  - All other bits are ignored.
- Response word fields:
  - [31:30] status: 00 = ok, 01 = timeout, 10 = bad channel.
  - [29:28] = 0.
  - [27:24] = channel.
  - [23:0] = echo width in clk cycles, zero-extended from CNT_W.
- FIFOs:
  - Standard (non-FWFT) FIFOs; dout updates one cycle after an accepted rd_en.
  - wr_en while full is ignored. rd_en while empty is ignored and dout holds its value.
  - Simultaneous read and write are legal in the same cycle, including at full or empty.
  - full and empty are registered and reflect the operation at the same edge.
- Echo input: each sig pin is sampled through a 2-flop synchroniser. All echo decisions use the synchronised value.
- Pin drive: a channel's sig is driven 1 only while it is the selected channel in TRIG. At all other times it is Z.
- FSM states:
  - IDLE: if the command FIFO is not empty, pop one word and go to DECODE.
  - DECODE:
    - Single mode with channel >= CH_NUM: go to PUSH with status 10 and width 0. No pin activity.
    - Otherwise latch the channel (0 in scan mode) and go to TRIG.
  - TRIG: drive the pin high for exactly TRIG_CYCLES cycles, then release and go to WAIT_RISE. Clear the timeout counter.
  - WAIT_RISE:
    - Timeout counter increments every cycle.
    - Synchronised rising edge seen: go to MEASURE with the width counter at 0.
    - Counter reaches TIMEOUT_CYCLES: go to PUSH with status 01 and width 0.
  - MEASURE:
    - Width counter and timeout counter both increment each cycle the synchronised pin is high.
    - On a synchronised falling edge: status 00, width = number of high cycles counted; go to PUSH.
    - If the timeout counter reaches TIMEOUT_CYCLES first: status 01, width = count so far; go to PUSH.
  - PUSH:
    - Wait while the response FIFO is full; the FSM stalls and the pins stay released.
    - Write the response word and go to HOLDOFF, or to IDLE for a bad-channel response.
  - HOLDOFF:
    - Wait HOLDOFF_CYCLES cycles.
    - In scan mode with channel < CH_NUM-1: increment the channel and go to TRIG.
    - Otherwise go to IDLE.
- Scan mode produces exactly CH_NUM responses, in channel order, with no other command interleaved.
- An echo already high on entry to WAIT_RISE does not count as a rising edge; only a low-to-high transition does.
- Commands written while busy queue in the command FIFO.

Test Plan:
- Test parameters: TRIG_CYCLES=4, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=8, FIFO_DEPTH=4.
- Single ok: write 0x00000002; the model raises sig[2] 10 cycles after release and holds it high 37 cycles -> sig[2] driven high exactly 4 cycles, one response 0x02000025, busy returns to 0.
- Timeout: write 0x00000001, with no echo -> response 0x41000000, and a next command is accepted after HOLDOFF. Also an echo high for 200 cycles -> status 01 with width < 100.
- Bad channel: write 0x00000007 (CH_NUM=4) -> response 0x87000000, no pin ever driven.
- Scan: write 0x00000100 with echo widths 5/6/7/8 on channels 0..3 -> responses 0x00000005, 0x01000006, 0x02000007, 0x03000008, in order.
- Backpressure/full:
  - Write 6 commands back-to-back -> full asserts after 4 are buffered and the extra writes are dropped.
  - With rd_en held low, the FSM stalls in PUSH after 4 responses, and resumes when one word is read.
- Reset mid-MEASURE: assert rst during an echo -> pins Z, empty=1, full=0, busy=0 next cycle, no response emitted.
